heaa_err_monitor: RTL and testbench

Sequential error-statistics monitor for the 32-bit approximate adders. It sits downstream of an approximate adder instance, the result-consuming end of its `a`/`b`/`sum` interface. It receives each operand pair with the adder's approximate 33-bit sum and computes the exact sum internally. Over a fixed window of samples it accumulates error count, maximum error distance and summed error distance, then presents the statistics on a valid/ready report port.

---
 rtl/heaa_err_monitor.sv | 130 +++++++++++++
 tb/tb_heaa_err_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/heaa_err_monitor.sv
// heaa_err_monitor: windowed error statistics (count, max, sum of |exact - approx|)
// for a 32-bit approximate adder. Define HEAA_MON_BIAS_EN to enable the signed bias sum.
module heaa_err_monitor #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = $clog2(WINDOW) + 1,
  parameter int ED_W   = 33,
  parameter int ACC_W  = ED_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [32:0]      approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  output logic [32:0]      max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic [ACC_W:0]   err_bias
);

  typedef enum logic [1:0] {COLLECT, DRAIN, REPORT} state_t;

  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept, last_accept, report_done;

  logic [32:0]      exact;
  logic [33:0]      diff;
  logic [32:0]      ed;

  logic             s1_valid;
  logic             s1_nz;
  logic [32:0]      s1_ed;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == LAST_CNT);
  assign report_done = out_valid && out_ready;

  // diff = exact - approx in 34-bit two's complement; its magnitude always fits 33 bits.
  assign exact = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, exact} - {1'b0, approx_sum};
  assign ed    = diff[33] ? 33'(-diff) : diff[32:0];

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // FSM next-state logic; DRAIN lasts exactly one cycle, while S1 hands the final sample to S2.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      COLLECT: if (last_accept) state_nxt = DRAIN;
      DRAIN:   state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: in_ready  = (acc_cnt < WIN_CNT);
      REPORT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || report_done) acc_cnt <= '0;
    else if (accept)        acc_cnt <= acc_cnt + 1'b1;
  end

  // Stage 1: register the error distance of the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_nz    <= 1'b0;
      s1_ed    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_nz <= (ed != '0);
        s1_ed <= ed;
      end
    end
  end

  // Stage 2: accumulators double as the report registers; cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst || report_done) begin
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else if (s1_valid) begin
      err_count <= err_count + CNT_W'(s1_nz);
      if (s1_ed > max_ed) max_ed <= s1_ed;
      sum_ed    <= sum_ed + ACC_W'(s1_ed);
    end
  end

`ifdef HEAA_MON_BIAS_EN
  logic [33:0] s1_diff;

  always_ff @(posedge clk) begin
    if (rst)         s1_diff <= '0;
    else if (accept) s1_diff <= diff;
  end

  // Bias is approx - exact, so subtract the sign-extended (exact - approx).
  always_ff @(posedge clk) begin
    if (rst || report_done) err_bias <= '0;
    else if (s1_valid)      err_bias <= err_bias - {{(ACC_W + 1 - 34){s1_diff[33]}}, s1_diff};
  end
`else
  assign err_bias = '0;
`endif

endmodule

// File: tb/tb_heaa_err_monitor.sv
// Self-checking bench for heaa_err_monitor: directed windows plus randomized samples
// compared against a queue-based statistics model.
module tb_heaa_err_monitor;
  localparam int     WINDOW = 256;
  localparam int     CNT_W  = $clog2(WINDOW) + 1;
  localparam int     ACC_W  = 33 + CNT_W;
  localparam longint MAX33  = (longint'(1) << 33) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      a, b;
  logic [32:0]      approx_sum;
  logic [CNT_W-1:0] err_count;
  logic [32:0]      max_ed;
  logic [ACC_W-1:0] sum_ed;
  logic [ACC_W:0]   err_bias;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every accepted sample of the current window as (|ED|, approx - exact).
  longint q_ed[$];
  longint q_bias[$];

  heaa_err_monitor #(.WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed), .err_bias(err_bias)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] sa, input logic [31:0] sb, input logic [32:0] sap,
                      input int max_gap);
    int     gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    longint d;
    in_valid = 1'b0;
    repeat (gap) begin
      a = $urandom; b = $urandom; approx_sum = {$urandom_range(1, 0) == 1, $urandom};
      tick();
    end
    a = sa; b = sb; approx_sum = sap; in_valid = 1'b1;
    check("in_ready_collect", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    d = longint'(sap) - (longint'(sa) + longint'(sb));
    q_ed.push_back(d < 0 ? -d : d);
    q_bias.push_back(d);
  endtask

  task automatic send_exact(input int max_gap);
    logic [31:0] ra = $urandom;
    logic [31:0] rb = $urandom;
    send(ra, rb, {1'b0, ra} + {1'b0, rb}, max_gap);
  endtask

  task automatic send_rand(input int max_gap);
    logic [31:0] ra = $urandom;
    logic [31:0] rb = $urandom;
    longint      ex = longint'(ra) + longint'(rb);
    longint      ap;
    case ($urandom_range(3, 0))
      0, 1:    ap = ex;
      2:       ap = ex + longint'($urandom_range(64, 0)) - 32;
      default: ap = ($urandom_range(1, 0) == 1) ? MAX33 : 0;
    endcase
    if (ap < 0) ap = 0;
    if (ap > MAX33) ap = MAX33;
    send(ra, rb, ap[32:0], max_gap);
  endtask

  task automatic check_report(input string tag);
    longint         cnt = 0, mx = 0, sm = 0, bs = 0;
    logic [ACC_W:0] eb;
    foreach (q_ed[i]) begin
      if (q_ed[i] != 0) cnt++;
      if (q_ed[i] > mx) mx = q_ed[i];
      sm += q_ed[i];
      bs += q_bias[i];
    end
`ifndef HEAA_MON_BIAS_EN
    bs = 0;
`endif
    eb = bs[ACC_W:0];
    check({tag, "_err_count"}, 64'(err_count), 64'(cnt));
    check({tag, "_max_ed"},    64'(max_ed),    64'(mx));
    check({tag, "_sum_ed"},    64'(sum_ed),    64'(sm));
    check({tag, "_err_bias"},  64'(err_bias),  64'(eb));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_max_ed"},    64'(max_ed),    64'd0);
    check({tag, "_sum_ed"},    64'(sum_ed),    64'd0);
    check({tag, "_err_bias"},  64'(err_bias),  64'd0);
  endtask

  // Called in the cycle after the final accept; walks DRAIN, REPORT and the handshake.
  task automatic finish_window(input string tag, input int hold, input bit pre_ready);
    check({tag, "_drain_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_drain_out_valid"}, 64'(out_valid), 64'd0);
    out_ready = pre_ready;
    tick();
    check({tag, "_report_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_report_in_ready"},  64'(in_ready),  64'd0);
    check_report(tag);
    if (!pre_ready) begin
      in_valid = 1'b1;
      repeat (hold) begin
        a = $urandom; b = $urandom; approx_sum = {1'b1, $urandom};
        tick();
        check({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_in_ready"},  64'(in_ready),  64'd0);
      end
      if (hold > 0) check_report({tag, "_stable"});
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check_cleared({tag, "_after_hs"});
    q_ed.delete();
    q_bias.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_cleared(tag);
    q_ed.delete();
    q_bias.delete();
  endtask

  initial begin
    a = '0; b = '0; approx_sum = '0;
    do_reset("reset");

    // All-exact window.
    for (int i = 0; i < WINDOW; i++) send(32'h0000_1000, 32'h0000_0001, 33'h0_0000_1001, 0);
    finish_window("exact", 0, 1'b0);

    // Single under-estimate of one.
    for (int i = 0; i < WINDOW; i++) begin
      if (i == 17) send(32'h0000_0FFF, 32'h0000_0001, 33'h0_0000_0FFF, 0);
      else         send_exact(0);
    end
    finish_window("single", 0, 1'b0);

    // Mixed errors 5, 2^32, 3 (last one in the final slot); consumer stalls 10 cycles.
    for (int i = 0; i < WINDOW; i++) begin
      if (i == 0)               send(32'd10, 32'd0, 33'd15, 1);
      else if (i == 100)        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFE, 1);
      else if (i == WINDOW - 1) send(32'd1, 32'd2, 33'd0, 1);
      else                      send_exact(1);
    end
    finish_window("mixed", 10, 1'b0);

    // Full-scale errors of both signs: accumulators must not wrap.
    for (int i = 0; i < WINDOW; i++) begin
      if (i % 3 == 0) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'd0, 0);
      else            send(32'd0, 32'd0, 33'h1_FFFF_FFFF, 0);
    end
    finish_window("extreme", 2, 1'b0);

    // Random windows with in_valid gaps; one with out_ready raised early.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WINDOW; i++) send_rand(3);
      finish_window($sformatf("rand%0d", w), int'($urandom_range(4, 0)), w == 1);
    end

    // Reset mid-window with a sample still in flight.
    for (int i = 0; i < 100; i++) send(32'($urandom), 32'd7, 33'd0, 0);
    do_reset("reset_mid_window");
    for (int i = 0; i < WINDOW; i++) send_rand(1);
    finish_window("post_reset", 3, 1'b0);

    // Reset while a report is pending.
    for (int i = 0; i < WINDOW; i++) send_rand(0);
    tick();
    check("pre_reset_report_out_valid", 64'(out_valid), 64'd1);
    do_reset("reset_mid_report");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
